// File: rtl/fifo_flex.sv
// fifo_flex: single-clock FIFO with any DEPTH, an occupancy count,
// almost-full/almost-empty thresholds, overflow/underflow error pulses,
// and a choice of show-ahead (FWFT=1) or registered (FWFT=0) read.
module fifo_flex #(
  parameter int WIDTH      = 256,
  parameter int DEPTH      = 4,
  parameter int AFULL_THR  = 3,
  parameter int AEMPTY_THR = 1,
  parameter int FWFT       = 1,
  localparam int CW        = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = $clog2(DEPTH);

  // Reject parameter sets that would make the flags meaningless.
  if (DEPTH < 2 || AFULL_THR < 1 || AFULL_THR > DEPTH ||
      AEMPTY_THR < 0 || AEMPTY_THR >= DEPTH) begin : g_bad_params
    $error("fifo_flex: illegal DEPTH/AFULL_THR/AEMPTY_THR combination");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrptr, rdptr;
  logic             wr_ok, rd_ok;

  // DEPTH need not be a power of two, so wrap on an explicit compare.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // Flags decode straight from the count register.
  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AFULL_THR));
  assign almost_empty = (count <= CW'(AEMPTY_THR));

  // A pop frees a slot this cycle, so a full FIFO may accept a write alongside it.
  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_ok);

  // Storage: not reset; writes are ignored while rst is held.
  always_ff @(posedge clk) begin
    if (wr_ok && !rst) mem[wrptr] <= wr_data;
  end

  // Pointers, occupancy and the one-cycle error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrptr     <= '0;
      rdptr     <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wrptr <= ptr_inc(wrptr);
      if (rd_ok) rdptr <= ptr_inc(rdptr);
      if (wr_ok && !rd_ok)      count <= count + 1'b1;
      else if (rd_ok && !wr_ok) count <= count - 1'b1;
      overflow  <= wr_en & ~wr_ok;
      underflow <= rd_en & empty;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is always presented; valid whenever something is stored.
    assign rd_data  = mem[rdptr];
    assign rd_valid = ~empty;
  end else begin : g_reg
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;
    // Registered read: data lands one cycle after the accepted pop and holds after.
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_ok;
        if (rd_ok) rd_data_q <= mem[rdptr];
      end
    end
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_fifo_flex.sv
// tb_fifo_flex: directed tests for fifo_flex; one show-ahead instance (a_*)
// and one registered-read instance (b_*), both DEPTH=5, AFULL=4, AEMPTY=1.
module tb_fifo_flex;

  localparam int W  = 8;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          a_wr_en = 0, a_rd_en = 0;
  logic [W-1:0]  a_wr_data = '0, a_rd_data;
  logic          a_rd_valid, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic [CW-1:0] a_count;

  logic          b_wr_en = 0, b_rd_en = 0;
  logic [W-1:0]  b_wr_data = '0, b_rd_data;
  logic          b_rd_valid, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [CW-1:0] b_count;

  fifo_flex #(.WIDTH(W), .DEPTH(5), .AFULL_THR(4), .AEMPTY_THR(1), .FWFT(1)) u_a (
    .clk(clk), .rst(rst), .wr_en(a_wr_en), .wr_data(a_wr_data), .rd_en(a_rd_en),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid), .full(a_full), .empty(a_empty),
    .almost_full(a_af), .almost_empty(a_ae), .count(a_count),
    .overflow(a_ovf), .underflow(a_unf));

  fifo_flex #(.WIDTH(W), .DEPTH(5), .AFULL_THR(4), .AEMPTY_THR(1), .FWFT(0)) u_b (
    .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_data(b_wr_data), .rd_en(b_rd_en),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .full(b_full), .empty(b_empty),
    .almost_full(b_af), .almost_empty(b_ae), .count(b_count),
    .overflow(b_ovf), .underflow(b_unf));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One clock on instance A with the given request; outputs settle #1 after the edge.
  task automatic a_cyc(input logic we, input logic [W-1:0] wd, input logic re);
    a_wr_en = we; a_wr_data = wd; a_rd_en = re;
    @(posedge clk); #1;
    a_wr_en = 0; a_rd_en = 0;
  endtask

  task automatic b_cyc(input logic we, input logic [W-1:0] wd, input logic re);
    b_wr_en = we; b_wr_data = wd; b_rd_en = re;
    @(posedge clk); #1;
    b_wr_en = 0; b_rd_en = 0;
  endtask

  // Show-ahead pop: head word must be on rd_data before the pop edge.
  task automatic a_pop(input string tag, input logic [W-1:0] exp);
    chk(tag, a_rd_data, exp);
    chk({tag, "_vld"}, a_rd_valid, 1);
    a_cyc(0, '0, 1);
  endtask

  initial begin
    // reset
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_count", a_count, 0);
    chk("rst_empty", a_empty, 1);
    chk("rst_full",  a_full, 0);
    chk("rst_ae",    a_ae, 1);
    chk("rst_af",    a_af, 0);
    chk("rst_ovf",   a_ovf, 0);
    chk("rst_unf",   a_unf, 0);
    chk("rst_vld_a", a_rd_valid, 0);
    chk("rst_vld_b", b_rd_valid, 0);
    chk("rst_data_b", b_rd_data, 0);

    // 1: fill with 0xA..0xE, then drain in order
    for (int i = 0; i < 5; i++) begin
      a_cyc(1, W'(8'h0A + i), 0);
      chk("t1_cnt", a_count, i + 1);
      chk("t1_af", a_af, (i + 1) >= 4);
      chk("t1_ae", a_ae, (i + 1) <= 1);
    end
    chk("t1_full", a_full, 1);
    for (int i = 0; i < 5; i++) begin
      a_pop("t1_rd", W'(8'h0A + i));
      chk("t1_dcnt", a_count, 4 - i);
    end
    chk("t1_empty", a_empty, 1);
    chk("t1_novld", a_rd_valid, 0);

    // 2: alternating write/read of 1..12 wraps the pointers twice
    for (int v = 1; v <= 12; v++) begin
      a_cyc(1, W'(v), 0);
      chk("t2_cnt1", a_count, 1);
      a_pop("t2_rd", W'(v));
      chk("t2_cnt0", a_count, 0);
    end

    // 3: overflow on full, then simultaneous push/pop on full
    for (int v = 1; v <= 5; v++) a_cyc(1, W'(v), 0);
    chk("t3_full", a_full, 1);
    a_cyc(1, 8'hFF, 0);
    chk("t3_ovf", a_ovf, 1);
    chk("t3_cnt", a_count, 5);
    a_cyc(0, '0, 0);
    chk("t3_ovf_clr", a_ovf, 0);
    chk("t3_rd_head", a_rd_data, 1);
    a_cyc(1, 8'h66, 1);
    chk("t3_ovf_rw", a_ovf, 0);
    chk("t3_cnt_rw", a_count, 5);
    a_pop("t3_rd2", 2);
    a_pop("t3_rd3", 3);
    a_pop("t3_rd4", 4);
    a_pop("t3_rd5", 5);
    a_pop("t3_rd66", 8'h66);
    chk("t3_empty", a_empty, 1);

    // 4: read on empty refused, concurrent write accepted
    a_cyc(1, 8'h33, 1);
    chk("t4_unf", a_unf, 1);
    chk("t4_cnt", a_count, 1);
    a_cyc(0, '0, 0);
    chk("t4_unf_clr", a_unf, 0);
    a_pop("t4_rd", 8'h33);
    chk("t4_empty", a_empty, 1);

    // 5: registered read on instance B
    b_cyc(1, 8'h11, 0);
    b_cyc(1, 8'h22, 0);
    chk("t5_novld", b_rd_valid, 0);
    b_cyc(0, '0, 1);
    chk("t5_vld1", b_rd_valid, 1);
    chk("t5_d1", b_rd_data, 8'h11);
    b_cyc(0, '0, 0);
    chk("t5_vld1_off", b_rd_valid, 0);
    chk("t5_d1_hold", b_rd_data, 8'h11);
    b_cyc(0, '0, 1);
    chk("t5_vld2", b_rd_valid, 1);
    chk("t5_d2", b_rd_data, 8'h22);
    b_cyc(0, '0, 0);
    chk("t5_vld2_off", b_rd_valid, 0);
    for (int k = 1; k <= 5; k++) begin
      b_cyc(1, W'(k), 0);
      chk("t5_fill_af", b_af, k >= 4);
      chk("t5_fill_ae", b_ae, k <= 1);
    end
    for (int k = 4; k >= 0; k--) begin
      b_cyc(0, '0, 1);
      chk("t5_drn_d", b_rd_data, 5 - k);
      chk("t5_drn_af", b_af, k >= 4);
      chk("t5_drn_ae", b_ae, k <= 1);
    end
    b_cyc(0, '0, 1);
    chk("t5_unf", b_unf, 1);
    chk("t5_unf_vld", b_rd_valid, 0);

    // 6: reset mid-operation with both requests active
    for (int v = 1; v <= 3; v++) a_cyc(1, W'(8'h40 + v), 0);
    chk("t6_cnt3", a_count, 3);
    rst = 1;
    a_cyc(1, 8'h99, 1);
    rst = 0;
    chk("t6_cnt", a_count, 0);
    chk("t6_empty", a_empty, 1);
    chk("t6_ovf", a_ovf, 0);
    chk("t6_unf", a_unf, 0);
    a_cyc(0, '0, 0);
    chk("t6_unf2", a_unf, 0);
    chk("t6_cnt2", a_count, 0);
    a_cyc(1, 8'h77, 0);
    a_pop("t6_rd", 8'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
